credit_link_arbiter: RTL and testbench

//  Shares one credit-based interconnect link between NUM_REQ upstream requesters.

---
 rtl/credit_pkg.sv | 22 ++
 rtl/credit_link_arbiter_if.sv | 57 +++++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/credit_link_arbiter.sv | 154 +++++++++++++++
 tb/tb_credit_link_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/credit_pkg.sv
// credit_pkg
//   Shared types and width helpers for the credit link arbiter slice.
//   Contents:
//     arb_state_e   packet-lock FSM states (used when CREDIT_ARB_LOCK_EN is defined)
//     credit_width  bits needed to hold a credit count of 0..max_credit
//     idx_width     bits needed to hold a requester index (at least 1)
package credit_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int credit_width(input int max_credit);
        return $clog2(max_credit + 1);
    endfunction

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/credit_link_arbiter_if.sv
// credit_link_arbiter_if
//   Requester-side and link-side signals of the credit link arbiter.
//   Parameters: DATA_WIDTH, NUM_REQ, MAX_CREDIT (must match the arbiter).
//   Signals:
//     i_req_valid        per-requester beat valid
//     i_req_data         requester data, requester r at [r*DATA_WIDTH +: DATA_WIDTH]
//     i_req_last         per-requester end-of-packet (only with CREDIT_ARB_LOCK_EN)
//     o_req_ready        one-hot accept
//     o_data / o_valid   registered link beat
//     i_increment_count  one credit returned by the far end
//     o_credit_count     current credits
//     o_credit_overflow  sticky credit-return overflow flag
//   Modports: master (requesters + far end), slave (arbiter).
//   Macro: CREDIT_ARB_LOCK_EN adds i_req_last.
interface credit_link_arbiter_if
    import credit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_CREDIT = 8
);
    localparam int CW = credit_width(MAX_CREDIT);

    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [DATA_WIDTH-1:0]         o_data;
    logic                          o_valid;
    logic                          i_increment_count;
    logic [CW-1:0]                 o_credit_count;
    logic                          o_credit_overflow;

`ifdef CREDIT_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            i_req_last;

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_increment_count,
        input  o_req_ready, o_data, o_valid, o_credit_count, o_credit_overflow
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_increment_count,
        output o_req_ready, o_data, o_valid, o_credit_count, o_credit_overflow
    );
`else
    modport master (
        output i_req_valid, i_req_data, i_increment_count,
        input  o_req_ready, o_data, o_valid, o_credit_count, o_credit_overflow
    );

    modport slave (
        input  i_req_valid, i_req_data, i_increment_count,
        output o_req_ready, o_data, o_valid, o_credit_count, o_credit_overflow
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker: grants the first asserted request at or
//   after 'pointer', wrapping around.
//   Ports:
//     req          in   NUM_REQ  request vector
//     pointer      in   IW       highest-priority requester index (< NUM_REQ)
//     grant        out  NUM_REQ  one-hot grant (all zero if no request)
//     grant_idx    out  IW       index of the granted requester
//     grant_valid  out  1        some request was granted
module rr_arbiter
    import credit_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_valid
);

    logic [IW-1:0] cand;

    // Scan NUM_REQ positions starting at the pointer; the wrap is done with a
    // subtract so non-power-of-two NUM_REQ works.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(pointer) + k >= NUM_REQ) begin
                cand = IW'(int'(pointer) + k - NUM_REQ);
            end else begin
                cand = IW'(int'(pointer) + k);
            end
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_link_arbiter.sv
// credit_link_arbiter
//   Shares one credit-based link between NUM_REQ requesters. Keeps the link's
//   credit counter, round-robin arbitrates, and issues at most one registered
//   beat per cycle while credit > 0.
//   Ports:
//     clock   in  posedge clock
//     resetn  in  asynchronous active-low reset
//     link    credit_link_arbiter_if.slave (requester handshake, link beat,
//             credit return, credit count, overflow flag)
//   Macro: CREDIT_ARB_LOCK_EN enables packet locking via i_req_last
//   (IDLE/LOCKED FSM); without it every beat is re-arbitrated.
module credit_link_arbiter
    import credit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_CREDIT = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    credit_link_arbiter_if.slave link
);

    localparam int CW = credit_width(MAX_CREDIT);
    localparam int IW = idx_width(NUM_REQ);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(MAX_CREDIT);
    localparam logic [IW-1:0] LAST_REQ    = IW'(NUM_REQ - 1);

    logic [CW-1:0]         credit;
    logic                  overflow;
    logic [IW-1:0]         rr_ptr;
    logic [NUM_REQ-1:0]    lock_mask;
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         grant_idx;
    logic                  grant_valid;
    logic                  transfer;
    logic                  ptr_advance;
    logic [IW-1:0]         ptr_after_grant;
    logic [DATA_WIDTH-1:0] grant_data;

`ifdef CREDIT_ARB_LOCK_EN
    arb_state_e    state, state_next;
    logic [IW-1:0] lock_idx, lock_idx_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ARB_IDLE;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            lock_idx <= lock_idx_next;
        end
    end

    // The pointer only moves when a packet ends, so after a locked packet the
    // next arbitration starts just past the requester that owned the link.
    always_comb begin
        state_next    = state;
        lock_idx_next = lock_idx;
        lock_mask     = '1;
        ptr_advance   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (transfer) begin
                    if (link.i_req_last[grant_idx]) begin
                        ptr_advance = 1'b1;
                    end else begin
                        state_next    = ARB_LOCKED;
                        lock_idx_next = grant_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                lock_mask           = '0;
                lock_mask[lock_idx] = 1'b1;
                if (transfer && link.i_req_last[grant_idx]) begin
                    state_next  = ARB_IDLE;
                    ptr_advance = 1'b1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end
`else
    assign lock_mask   = '1;
    assign ptr_advance = transfer;
`endif

    // No request reaches the arbiter at zero credit; a return arriving in the
    // same cycle only becomes usable once it is registered.
    assign arb_req = (credit != '0) ? (link.i_req_valid & lock_mask) : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req         (arb_req),
        .pointer     (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Grants are only given to valid requesters, so a grant is a transfer.
    assign transfer         = grant_valid;
    assign link.o_req_ready = grant;
    assign grant_data       = link.i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_after_grant  = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            link.o_valid <= 1'b0;
            link.o_data  <= '0;
        end else begin
            link.o_valid <= transfer;
            if (transfer) begin
                link.o_data <= grant_data;
            end
        end
    end

    // A send and a return in the same cycle cancel. A return with a full
    // counter means the far end returned more than it was given.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            credit   <= CREDIT_FULL;
            overflow <= 1'b0;
        end else begin
            case ({transfer, link.i_increment_count})
                2'b10: credit <= credit - 1'b1;
                2'b01: begin
                    if (credit == CREDIT_FULL) begin
                        overflow <= 1'b1;
                    end else begin
                        credit <= credit + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (ptr_advance) begin
            rr_ptr <= ptr_after_grant;
        end
    end

    assign link.o_credit_count    = credit;
    assign link.o_credit_overflow = overflow;

endmodule

// File: tb/tb_credit_link_arbiter.sv
// tb_credit_link_arbiter
//   Self-checking bench for credit_link_arbiter. A behavioural model (integer
//   credit count, integer pointer, optional locked-requester index) predicts
//   grants and registered outputs; directed scenarios add fixed expectations.
//   Macro: CREDIT_ARB_LOCK_EN enables the packet-lock scenario and model rules.
module tb_credit_link_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int MC = 8;
    localparam int CW = $clog2(MC + 1);

    logic clock;
    logic resetn;

    int vectors     = 0;
    int miscompares = 0;

    int          m_credit;
    int          m_ptr;
    int          m_lock;
    logic        m_overflow;
    logic        m_valid;
    logic [DW-1:0] m_data;

    credit_link_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_CREDIT(MC)) lnk ();

    credit_link_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_CREDIT(MC)) dut (
        .clock  (clock),
        .resetn (resetn),
        .link   (lnk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_credit   = MC;
        m_ptr      = 0;
        m_lock     = -1;
        m_overflow = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
    endtask

    // Requester expected to be granted with the inputs currently applied, or -1.
    function automatic int model_grant();
        if (m_credit == 0) return -1;
        if (m_lock >= 0) return lnk.i_req_valid[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            int r;
            r = (m_ptr + k) % N;
            if (lnk.i_req_valid[r]) return r;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_commit(input int g);
        logic ret;
        ret = lnk.i_increment_count;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = lnk.i_req_data[g*DW +: DW];
`ifdef CREDIT_ARB_LOCK_EN
            if (lnk.i_req_last[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % N;
            end else begin
                m_lock = g;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else begin
            m_valid = 1'b0;
        end
        if (g >= 0 && !ret) begin
            m_credit = m_credit - 1;
        end else if (g < 0 && ret) begin
            if (m_credit == MC) m_overflow = 1'b1;
            else m_credit = m_credit + 1;
        end
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] one;
        one = 1;
        return (g >= 0) ? (one << g) : '0;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic ret, input logic [N-1:0] last);
        @(negedge clock);
        lnk.i_req_valid       = v;
        lnk.i_increment_count = ret;
        for (int r = 0; r < N; r++) lnk.i_req_data[r*DW +: DW] = $urandom();
`ifdef CREDIT_ARB_LOCK_EN
        lnk.i_req_last = last;
`else
        if (last != '0) lnk.i_req_data[0] = lnk.i_req_data[0];
`endif
    endtask

    task automatic clear_inputs();
        lnk.i_req_valid       = '0;
        lnk.i_req_data        = '0;
        lnk.i_increment_count = 1'b0;
`ifdef CREDIT_ARB_LOCK_EN
        lnk.i_req_last = '0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetn = 1'b0;
        clear_inputs();
        lnk.i_req_valid = 4'b1111;
        #1;
        vectors++;
        if (lnk.o_credit_count !== CW'(MC) || lnk.o_valid !== 1'b0 || lnk.o_data !== '0 ||
            lnk.o_credit_overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state credit=%0d valid=%b data=%h ovf=%b required credit=%0d valid=0 data=0 ovf=0",
                     lnk.o_credit_count, lnk.o_valid, lnk.o_data, lnk.o_credit_overflow, MC);
        end
        @(negedge clock);
        clear_inputs();
        model_reset();
        resetn = 1'b1;
        #1;
        vectors++;
        if (lnk.o_req_ready !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready got=%b required=0000", lnk.o_req_ready);
        end
    endtask

    // Requester 0 alone, no returns: eight beats, then ready stays low.
    task automatic test_credit_drain();
        int g;
        int beats;
        int exp_credit;
        beats = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(4'b0001, 1'b0, '0);
            #1;
            g = model_grant();
            vectors++;
            if (lnk.o_req_ready !== ((i < 8) ? 4'b0001 : 4'b0000)) begin
                miscompares++;
                $display("[TB] FAIL drain_ready cyc=%0d got=%b required=%b", i, lnk.o_req_ready,
                         (i < 8) ? 4'b0001 : 4'b0000);
            end
            model_commit(g);
            @(posedge clock);
            #1;
            if (lnk.o_valid === 1'b1) beats++;
            exp_credit = (i < 8) ? 7 - i : 0;
            vectors++;
            if (lnk.o_credit_count !== CW'(exp_credit) || lnk.o_data !== m_data) begin
                miscompares++;
                $display("[TB] FAIL drain_credit cyc=%0d credit=%0d data=%h required credit=%0d data=%h",
                         i, lnk.o_credit_count, lnk.o_data, exp_credit, m_data);
            end
        end
        vectors++;
        if (beats != 8) begin
            miscompares++;
            $display("[TB] FAIL drain_beats got=%0d required=8", beats);
        end
    endtask

    // Starts at zero credit: a return alongside a pending send gives no grant.
    task automatic test_zero_credit_return();
        int g;
        drive(4'b0001, 1'b1, '0);
        #1;
        g = model_grant();
        vectors++;
        if (lnk.o_req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL zero_ret_ready got=%b required=0000", lnk.o_req_ready);
        end
        model_commit(g);
        @(posedge clock);
        #1;
        vectors++;
        if (lnk.o_credit_count !== CW'(1) || lnk.o_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_ret_credit credit=%0d valid=%b required credit=1 valid=0",
                     lnk.o_credit_count, lnk.o_valid);
        end
        drive(4'b0001, 1'b0, '0);
        #1;
        g = model_grant();
        vectors++;
        if (lnk.o_req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL zero_next_ready got=%b required=0001", lnk.o_req_ready);
        end
        model_commit(g);
        @(posedge clock);
        #1;
        vectors++;
        if (lnk.o_credit_count !== CW'(0) || lnk.o_valid !== 1'b1 || lnk.o_data !== m_data) begin
            miscompares++;
            $display("[TB] FAIL zero_next_beat credit=%0d valid=%b data=%h required credit=0 valid=1 data=%h",
                     lnk.o_credit_count, lnk.o_valid, lnk.o_data, m_data);
        end
    endtask

    // All requesters valid with a return every cycle: 0,1,2,3,0,... at full credit.
    task automatic test_round_robin();
        int g;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(4'b1111, 1'b1, '0);
            #1;
            g = model_grant();
            vectors++;
            if (lnk.o_req_ready !== onehot(i % N)) begin
                miscompares++;
                $display("[TB] FAIL rr_ready cyc=%0d got=%b required=%b", i, lnk.o_req_ready, onehot(i % N));
            end
            model_commit(g);
            @(posedge clock);
            #1;
            vectors++;
            if (lnk.o_credit_count !== CW'(MC) || lnk.o_valid !== 1'b1 || lnk.o_data !== m_data) begin
                miscompares++;
                $display("[TB] FAIL rr_beat cyc=%0d credit=%0d valid=%b data=%h required credit=%0d valid=1 data=%h",
                         i, lnk.o_credit_count, lnk.o_valid, lnk.o_data, MC, m_data);
            end
        end
    endtask

    // Return at full credit saturates and sets the sticky overflow flag.
    task automatic test_overflow();
        int g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(4'b0000, 1'b1, '0);
                1, 2:    drive(4'b0001, 1'b0, '0);
                default: drive(4'b0000, 1'b0, '0);
            endcase
            #1;
            g = model_grant();
            model_commit(g);
            @(posedge clock);
            #1;
            vectors++;
            if (lnk.o_credit_overflow !== 1'b1 || lnk.o_credit_count !== CW'(m_credit)) begin
                miscompares++;
                $display("[TB] FAIL overflow cyc=%0d ovf=%b credit=%0d required ovf=1 credit=%0d",
                         i, lnk.o_credit_overflow, lnk.o_credit_count, m_credit);
            end
        end
    endtask

`ifdef CREDIT_ARB_LOCK_EN
    // Requester 1 sends a 3-beat packet while requester 2 waits its turn.
    task automatic test_lock_packet();
        int g;
        logic [N-1:0] v_tab [4]  = '{4'b0110, 4'b0110, 4'b0110, 4'b0100};
        logic [N-1:0] l_tab [4]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0100};
        logic [N-1:0] r_tab [4]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(v_tab[i], 1'b1, l_tab[i]);
            #1;
            g = model_grant();
            vectors++;
            if (lnk.o_req_ready !== r_tab[i]) begin
                miscompares++;
                $display("[TB] FAIL lock_ready beat=%0d got=%b required=%b", i, lnk.o_req_ready, r_tab[i]);
            end
            model_commit(g);
            @(posedge clock);
            #1;
            vectors++;
            if (lnk.o_valid !== 1'b1 || lnk.o_data !== m_data) begin
                miscompares++;
                $display("[TB] FAIL lock_beat beat=%0d valid=%b data=%h required valid=1 data=%h",
                         i, lnk.o_valid, lnk.o_data, m_data);
            end
        end
    endtask
`endif

    // Reset while a beat is on the link and credit is 3.
    task automatic test_reset_mid_transfer();
        int g;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, 1'b0, '0);
            #1;
            g = model_grant();
            model_commit(g);
            @(posedge clock);
        end
        #1;
        vectors++;
        if (lnk.o_valid !== 1'b1 || lnk.o_credit_count !== CW'(3)) begin
            miscompares++;
            $display("[TB] FAIL midrst_pre valid=%b credit=%0d required valid=1 credit=3",
                     lnk.o_valid, lnk.o_credit_count);
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if (lnk.o_valid !== 1'b0 || lnk.o_credit_count !== CW'(MC) || lnk.o_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_post valid=%b credit=%0d data=%h required valid=0 credit=%0d data=0",
                     lnk.o_valid, lnk.o_credit_count, lnk.o_data, MC);
        end
        @(negedge clock);
        clear_inputs();
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic ret;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v   = N'($urandom());
            ret = ($urandom_range(0, 1) == 1);
            for (int r = 0; r < N; r++) l[r] = ($urandom_range(0, 3) == 0);
            drive(v, ret, l);
            #1;
            g = model_grant();
            vectors++;
            if (lnk.o_req_ready !== onehot(g)) begin
                miscompares++;
                $display("[TB] FAIL rand_ready cyc=%0d got=%b required=%b", i, lnk.o_req_ready, onehot(g));
            end
            model_commit(g);
            @(posedge clock);
            #1;
            vectors++;
            if (lnk.o_valid !== m_valid || lnk.o_data !== m_data ||
                lnk.o_credit_count !== CW'(m_credit) || lnk.o_credit_overflow !== m_overflow) begin
                miscompares++;
                $display("[TB] FAIL rand_out cyc=%0d valid=%b data=%h credit=%0d ovf=%b required valid=%b data=%h credit=%0d ovf=%b",
                         i, lnk.o_valid, lnk.o_data, lnk.o_credit_count, lnk.o_credit_overflow,
                         m_valid, m_data, m_credit, m_overflow);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_credit_drain();
        test_zero_credit_return();
        test_round_robin();
        test_overflow();
`ifdef CREDIT_ARB_LOCK_EN
        test_lock_packet();
`endif
        test_reset_mid_transfer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
